// File: rtl/morph_window_unit.sv
// Sequential morphology kernel: reduces one captured window of WIN pixels to a single
// result pixel using binary erode/dilate (with early exit) or grayscale min/max.
module morph_window_unit #(
  parameter int DATA_W = 8,
  parameter int WIN    = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            mode_i,
  input  logic [WIN*DATA_W-1:0] pix_i,
  output logic [DATA_W-1:0]     veri_o,
  output logic                  valid_o,
  output logic                  busy_o
);

  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [DATA_W-1:0] ONES = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIN - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WIN*DATA_W-1:0]   r_win;
  logic [1:0]              r_mode;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_W-1:0]       r_acc;
  logic [DATA_W-1:0]       r_veri;
  logic                    r_valid;

  logic [DATA_W-1:0]       w_pix_arr [WIN];
  logic [DATA_W-1:0]       w_pix;
  logic [DATA_W-1:0]       w_min;
  logic [DATA_W-1:0]       w_max;
  logic [DATA_W-1:0]       w_result;
  logic                    w_last;
  logic                    w_finish;
  logic                    w_ready;

  for (genvar gi = 0; gi < WIN; gi++) begin : g_unpack
    assign w_pix_arr[gi] = r_win[gi*DATA_W +: DATA_W];
  end

  assign w_pix   = w_pix_arr[r_idx];
  assign w_min   = (w_pix < r_acc) ? w_pix : r_acc;
  assign w_max   = (w_pix > r_acc) ? w_pix : r_acc;
  assign w_last  = (r_idx == LAST_IDX);
  assign w_ready = en_i && (r_state == S_IDLE);

  assign ready_o = w_ready;
  assign veri_o  = r_veri;
  assign valid_o = r_valid;
  assign busy_o  = (r_state == S_SCAN);

  // Binary modes stop at the first deciding pixel; gray modes always run to the end.
  always_comb begin
    w_finish = 1'b0;
    w_result = '0;
    case (r_mode)
      2'd0: begin
        if (w_pix == '0) begin
          w_finish = 1'b1;
        end else if (w_last) begin
          w_finish = 1'b1;
          w_result = ONES;
        end
      end
      2'd1: begin
        if (w_pix != '0) begin
          w_finish = 1'b1;
          w_result = ONES;
        end else if (w_last) begin
          w_finish = 1'b1;
        end
      end
      2'd2: begin
        w_finish = w_last;
        w_result = w_min;
      end
      default: begin
        w_finish = w_last;
        w_result = w_max;
      end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (valid_i && w_ready) w_state_next = S_SCAN;
      S_SCAN:  if (w_finish) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (!en_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win   <= '0;
      r_mode  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_veri  <= '0;
      r_valid <= 1'b0;
    end else if (!en_i) begin
      r_idx   <= '0;
      r_veri  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (valid_i) begin
          r_win  <= pix_i;
          r_mode <= mode_i;
          r_idx  <= '0;
          r_acc  <= (mode_i == 2'd2) ? ONES : '0;
        end
      end else begin
        r_acc <= (r_mode == 2'd2) ? w_min : w_max;
        if (w_finish) begin
          r_veri  <= w_result;
          r_valid <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule
